// File: rtl/smac_seq.sv
// rtl/smac_seq.sv - bit-serial MAC sequencer: walks weight bits MSB-first and, for each,
// all activation bits MSB-first, emitting bit-planes and datapath strobes.
module smac_seq #(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int Pw = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M*Pa-1:0] act_in,
  input  logic [M*Pw-1:0] wei_in,
  output logic [M-1:0]  act_plane,
  output logic [M-1:0]  wei_plane,
  output logic          we_w,
  output logic          we_br,
  output logic          we_ac1,
  output logic          cl_en_ac1,
  output logic          we_neg,
  output logic          we_ac2,
  output logic          cl_en_ac2,
  output logic          MSB_a,
  output logic          MSB_w,
  output logic          res_valid,
  output logic          busy
);

  localparam int KW = (Pa > 1) ? $clog2(Pa) : 1;
  localparam int JW = (Pw > 1) ? $clog2(Pw) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, RUN_A, DRAIN, NEG, ACC2, DONE} state_t;

  state_t          state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic [M*Pa-1:0] act_q;
  logic [M*Pw-1:0] wei_q;
  logic [M-1:0]    act_bits, wei_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      k_q     <= '0;
      act_q   <= '0;
      wei_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      if (in_valid && in_ready) begin
        act_q <= act_in;
        wei_q <= wei_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = LOAD_W;
        j_d     = JW'(Pw - 1);
      end
      LOAD_W: begin
        state_d = RUN_A;
        k_d     = KW'(Pa - 1);
      end
      RUN_A: begin
        if (k_q == '0) state_d = DRAIN;
        else           k_d     = k_q - 1'b1;
      end
      DRAIN: state_d = NEG;
      NEG:   state_d = ACC2;
      ACC2: begin
        if (j_q != '0) begin
          state_d = LOAD_W;
          j_d     = j_q - 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        j_d     = '0;
        k_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-lane bit selection from the captured vectors at the current k / j.
  for (genvar gi = 0; gi < M; gi++) begin : g_lane
    logic [Pa-1:0] act_el;
    logic [Pw-1:0] wei_el;
    assign act_el       = act_q[gi*Pa +: Pa];
    assign wei_el       = wei_q[gi*Pw +: Pw];
    assign act_bits[gi] = act_el[k_q];
    assign wei_bits[gi] = wei_el[j_q];
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  always_comb begin
    act_plane = '0;
    wei_plane = '0;
    we_w      = 1'b0;
    we_br     = 1'b0;
    we_ac1    = 1'b0;
    cl_en_ac1 = 1'b0;
    we_neg    = 1'b0;
    we_ac2    = 1'b0;
    cl_en_ac2 = 1'b0;
    MSB_a     = 1'b0;
    MSB_w     = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      LOAD_W: begin
        wei_plane = wei_bits;
        we_w      = 1'b1;
        MSB_w     = (j_q == JW'(Pw - 1));
      end
      RUN_A: begin
        act_plane = act_bits;
        we_br     = 1'b1;
        MSB_a     = (k_q == KW'(Pa - 1));
        // Accumulator write trails the bit-plane read by one cycle.
        we_ac1    = (k_q != KW'(Pa - 1));
        cl_en_ac1 = (k_q == KW'(Pa - 2));
        MSB_w     = (j_q == JW'(Pw - 1));
      end
      DRAIN: begin
        we_ac1 = 1'b1;
        MSB_w  = (j_q == JW'(Pw - 1));
      end
      NEG: begin
        we_neg = 1'b1;
        MSB_w  = (j_q == JW'(Pw - 1));
      end
      ACC2: begin
        we_ac2    = 1'b1;
        cl_en_ac2 = (j_q == JW'(Pw - 1));
        MSB_w     = (j_q == JW'(Pw - 1));
      end
      DONE:    res_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smac_seq.sv
// tb/tb_smac_seq.sv - self-checking bench for smac_seq against a cycle-schedule model
// derived from weight/activation bit ordering.
module tb_smac_seq;
  localparam int M  = 16;
  localparam int Pa = 8;
  localparam int Pw = 4;
  localparam int LAT = Pw * (Pa + 4) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [M*Pa-1:0] act_in = '0;
  logic [M*Pw-1:0] wei_in = '0;
  logic [M-1:0]  act_plane, wei_plane;
  logic          we_w, we_br, we_ac1, cl_en_ac1, we_neg, we_ac2, cl_en_ac2;
  logic          MSB_a, MSB_w, res_valid, busy;

  int total = 0;
  int bad   = 0;
  int n_we_w, n_we_br, n_we_ac1, n_cl1, n_neg, n_ac2, n_cl2, n_res, n_msba, res_cycle;
  logic [M-1:0] a_planes[$];
  logic [M-1:0] w_planes[$];

  always #5 clk = ~clk;

  smac_seq #(.M(M), .Pa(Pa), .Pw(Pw)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .act_in(act_in), .wei_in(wei_in), .act_plane(act_plane), .wei_plane(wei_plane),
    .we_w(we_w), .we_br(we_br), .we_ac1(we_ac1), .cl_en_ac1(cl_en_ac1),
    .we_neg(we_neg), .we_ac2(we_ac2), .cl_en_ac2(cl_en_ac2),
    .MSB_a(MSB_a), .MSB_w(MSB_w), .res_valid(res_valid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] flags_now();
    return {we_w, we_br, we_ac1, cl_en_ac1, we_neg, we_ac2, cl_en_ac2,
            MSB_a, MSB_w, res_valid, busy, in_ready};
  endfunction

  // Expected outputs c cycles after the transfer edge, from the bit-serial schedule.
  task automatic model(input int c, input logic [M*Pa-1:0] a, input logic [M*Pw-1:0] w,
                       output logic [M-1:0] ea, output logic [M-1:0] ew,
                       output logic [11:0] ef);
    bit f_w, f_br, f_ac1, f_cl1, f_neg, f_ac2, f_cl2, f_ma, f_mw, f_res;
    int t, jj, p, k;
    ea = '0; ew = '0;
    {f_w, f_br, f_ac1, f_cl1, f_neg, f_ac2, f_cl2, f_ma, f_mw, f_res} = '0;
    if (c == LAT) begin
      f_res = 1;
    end else begin
      t  = c - 1;
      jj = Pw - 1 - t / (Pa + 4);
      p  = t % (Pa + 4);
      f_mw = (jj == Pw - 1);
      if (p == 0) begin
        f_w = 1;
        for (int i = 0; i < M; i++) ew[i] = w[i*Pw + jj];
      end else if (p <= Pa) begin
        k = Pa - p;
        f_br = 1;
        for (int i = 0; i < M; i++) ea[i] = a[i*Pa + k];
        f_ma  = (k == Pa - 1);
        f_ac1 = (k < Pa - 1);
        f_cl1 = (k == Pa - 2);
      end else if (p == Pa + 1) begin
        f_ac1 = 1;
      end else if (p == Pa + 2) begin
        f_neg = 1;
      end else begin
        f_ac2 = 1;
        f_cl2 = (jj == Pw - 1);
      end
    end
    ef = {f_w, f_br, f_ac1, f_cl1, f_neg, f_ac2, f_cl2, f_ma, f_mw, f_res, 1'b1, 1'b0};
  endtask

  task automatic clear_counts();
    {n_we_w, n_we_br, n_we_ac1, n_cl1, n_neg, n_ac2, n_cl2, n_res, n_msba} = '0;
    res_cycle = -1;
    a_planes.delete();
    w_planes.delete();
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of cycle LAT+1.
  task automatic do_txn(input logic [M*Pa-1:0] a, input logic [M*Pw-1:0] w, input bit hold);
    logic [M-1:0] ea, ew;
    logic [11:0]  ef;
    act_in = a; wei_in = w; in_valid = 1'b1;
    chk("ready_before", {63'd0, in_ready}, 64'd1);
    clear_counts();
    @(posedge clk);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (hold) begin
        act_in = {$urandom, $urandom, $urandom, $urandom};
        wei_in = {$urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      model(c, a, w, ea, ew, ef);
      chk($sformatf("act_plane c%0d", c), {48'd0, act_plane}, {48'd0, ea});
      chk($sformatf("wei_plane c%0d", c), {48'd0, wei_plane}, {48'd0, ew});
      chk($sformatf("flags c%0d", c), {52'd0, flags_now()}, {52'd0, ef});
      n_we_w += int'(we_w); n_we_br += int'(we_br); n_we_ac1 += int'(we_ac1);
      n_cl1 += int'(cl_en_ac1); n_neg += int'(we_neg); n_ac2 += int'(we_ac2);
      n_cl2 += int'(cl_en_ac2); n_res += int'(res_valid); n_msba += int'(MSB_a);
      if (res_valid) res_cycle = c;
      if (we_br) a_planes.push_back(act_plane);
      if (we_w)  w_planes.push_back(wei_plane);
    end
    @(negedge clk);
    chk("ready_after", {62'd0, in_ready, busy}, 64'd2);
    chk("no_res_after", {63'd0, res_valid}, 64'd0);
  endtask

  initial begin
    logic [M*Pa-1:0] a;
    logic [M*Pw-1:0] w;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_planes", {32'd0, act_plane, wei_plane}, 64'd0);
    chk("reset_flags", {52'd0, flags_now()}, 64'd1);

    // Single-lane directed pattern.
    a = '0; w = '0;
    a[7:0] = 8'b1000_0001;
    w[3:0] = 4'b1010;
    do_txn(a, w, 1'b0);
    chk("w_planes_n", 64'(w_planes.size()), 64'd4);
    if (w_planes.size() == 4) begin
      chk("w_plane0", {48'd0, w_planes[0]}, 64'h1);
      chk("w_plane1", {48'd0, w_planes[1]}, 64'h0);
      chk("w_plane2", {48'd0, w_planes[2]}, 64'h1);
      chk("w_plane3", {48'd0, w_planes[3]}, 64'h0);
    end
    chk("a_planes_n", 64'(a_planes.size()), 64'd32);
    if (a_planes.size() == 32) begin
      for (int i = 0; i < 8; i++)
        chk($sformatf("a_plane%0d", i), {48'd0, a_planes[i]},
            (i == 0 || i == 7) ? 64'h1 : 64'h0);
    end
    chk("cnt_we_w", 64'(n_we_w), 64'(Pw));
    chk("cnt_we_br", 64'(n_we_br), 64'(Pw * Pa));
    chk("cnt_we_ac1", 64'(n_we_ac1), 64'(Pw * Pa));
    chk("cnt_cl_en_ac1", 64'(n_cl1), 64'(Pw));
    chk("cnt_we_neg", 64'(n_neg), 64'(Pw));
    chk("cnt_we_ac2", 64'(n_ac2), 64'(Pw));
    chk("cnt_cl_en_ac2", 64'(n_cl2), 64'd1);
    chk("cnt_res_valid", 64'(n_res), 64'd1);
    chk("res_cycle", 64'(res_cycle), 64'd49);

    // All ones.
    do_txn('1, '1, 1'b0);
    chk("ones_msb_a", 64'(n_msba), 64'(Pw));
    foreach (a_planes[i]) chk($sformatf("ones_plane%0d", i), {48'd0, a_planes[i]}, 64'hFFFF);

    // Back-to-back with in_valid held high and data churning while busy.
    for (int n = 0; n < 3; n++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      w = {$urandom, $urandom};
      do_txn(a, w, 1'b1);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a run.
    a = {$urandom, $urandom, $urandom, $urandom};
    w = {$urandom, $urandom};
    act_in = a; wei_in = w; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_planes", {32'd0, act_plane, wei_plane}, 64'd0);
    chk("async_flags", {52'd0, flags_now()}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    n_res = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_res += int'(res_valid) + int'(busy);
    end
    chk("no_partial_result", 64'(n_res), 64'd0);
    a = {$urandom, $urandom, $urandom, $urandom};
    w = {$urandom, $urandom};
    do_txn(a, w, 1'b0);
    chk("post_reset_res_cycle", 64'(res_cycle), 64'd49);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/smac_seq.md
SMAC_SEQ -- requirements
Module: smac_seq

Interface
REQ-001 Parameter M, default 16, number of MAC lanes (elements per vector).
REQ-002 Parameter Pa, default 8, activation bit width.
REQ-003 Parameter Pw, default 4, weight bit width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  input vector offered.
REQ-007 in_ready  out  1  sequencer can accept a vector.
REQ-008 act_in  in  M*Pa  activations; element i = act_in[i*Pa +: Pa], two's complement.
REQ-009 wei_in  in  M*Pw  weights; element i = wei_in[i*Pw +: Pw], two's complement.
REQ-010 act_plane  out  M  activation bit-plane; bit i = bit k of activation i.
REQ-011 wei_plane  out  M  weight bit-plane; bit i = bit j of weight i.
REQ-012 we_w, we_br, we_ac1, cl_en_ac1, we_neg, we_ac2, cl_en_ac2  out  1 each  datapath strobes.
REQ-013 MSB_a, MSB_w  out  1 each  sign-bit flags for the current activation / weight bit.
REQ-014 res_valid  out  1  one-cycle pulse: datapath accumulator holds the final dot product.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 Transfer occurs on a rising edge with in_valid && in_ready; act_in/wei_in captured into internal registers at that edge; inputs ignored at all other times.
REQ-017 in_ready SHALL equal (state == IDLE), combinationally.
REQ-018 FSM states: IDLE, LOAD_W, RUN_A, DRAIN, NEG, ACC2, DONE.
REQ-019 Weight bit index j runs Pw-1 down to 0 (MSB first); per j the sequence is LOAD_W(1) -> RUN_A(Pa) -> DRAIN(1) -> NEG(1) -> ACC2(1), i.e. Pa+4 cycles.
REQ-020 IDLE -> LOAD_W on transfer, with j = Pw-1; ACC2 -> LOAD_W with j-1 if j > 0, else ACC2 -> DONE; DONE -> IDLE unconditionally.
REQ-021 LOAD_W: wei_plane = bit j of each captured weight, we_w = 1.
REQ-022 RUN_A: activation bit index k runs Pa-1 down to 0, one per cycle; act_plane = bit k planes, we_br = 1, MSB_a = (k == Pa-1).
REQ-023 we_ac1 = 1 in RUN_A cycles with k < Pa-1 and in DRAIN, giving Pa writes per j, each one cycle after the matching we_br.
REQ-024 cl_en_ac1 = 1 only with the first we_ac1 of each j (RUN_A, k = Pa-2).
REQ-025 NEG: we_neg = 1. ACC2: we_ac2 = 1, cl_en_ac2 = (j == Pw-1).
REQ-026 MSB_w = (j == Pw-1), held constant from LOAD_W through ACC2 of that j; 0 in IDLE and DONE.
REQ-027 act_plane = 0 outside RUN_A; wei_plane = 0 outside LOAD_W; each strobe is 0 in every state not listed for it.
REQ-028 DONE: res_valid = 1 for exactly one cycle.
REQ-029 Latency: transfer at edge E0 -> res_valid high in cycle Pw*(Pa+4)+1 after E0 (49 for defaults); in_ready high again the following cycle.
REQ-030 in_valid held high while busy SHALL NOT cause a capture or alter the sequence.
REQ-031 All outputs SHALL be registered except in_ready, busy and the single-cycle decoding of the state/counters.

Reset
REQ-032 rst asserted, at any time including mid-transaction: state = IDLE, j/k counters = 0, captured vectors = 0, all planes, strobes, MSB flags and res_valid = 0, busy = 0, in_ready = 1.
REQ-033 No partial result is signalled after a mid-run reset; the next transfer starts a full Pw*(Pa+4) sequence.

Verification
REQ-034 Reset: assert rst for 3 cycles, then release -> all outputs 0, in_ready = 1, busy = 0.
REQ-035 act elem0 = 8'b1000_0001, wei elem0 = 4'b1010, others 0 -> wei_plane per LOAD_W: 0x0001, 0x0000, 0x0001, 0x0000; act_plane per RUN_A: 0x0001, six 0x0000, 0x0001; MSB_w high only during j=3.
REQ-036 Defaults, one transaction -> counts: we_w 4, we_br 32, we_ac1 32, cl_en_ac1 4, we_neg 4, we_ac2 4, cl_en_ac2 1, res_valid 1 at cycle 49 after transfer.
REQ-037 All act = 0xFF, all wei = 0xF -> act_plane = 0xFFFF in all 32 RUN_A cycles; MSB_a high on 4 cycles (first of each RUN_A).
REQ-038 in_valid held high continuously with changing data -> captures only at cycle 0 and cycle 50; results sequence from the captured values only.
REQ-039 rst pulsed at cycle 20 of a transaction -> outputs 0 immediately (asynchronous), no res_valid; new transfer afterwards gives res_valid 49 cycles later.
